// File: rtl/riscv_sim_monitor_pkg.sv
// riscv_sim_monitor_pkg: shared state encoding and constants for the end-of-test monitor
package riscv_sim_monitor_pkg;
   typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TIMEOUT, LOCKED} state_t;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   // Wide enough for any DATA_W up to 65; the top slices it to DATA_W-1 bits
   localparam logic [63:0] TEST_ID_ALL_ONES = '1;
endpackage

// File: rtl/riscv_sim_monitor_cnt.sv
// riscv_sim_monitor_cnt: saturating up-counter with enable and sync clear
// Ports: clk_i clock, reset_i async active-low reset, en count enable,
//        clr sync clear (wins over en), cnt current count (sticks at all-ones)
module riscv_sim_monitor_cnt #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/riscv_sim_monitor.sv
// riscv_sim_monitor: read-only bus snooper that turns a tohost mailbox write, watchdog or core lock into a verdict
// Ports: clk_i/reset_i (async active-low); lock_i, ird_i, dwr_i, daddr_i, dwdata_i, dsize_i snooped bus;
//        done_o, pass_o, fail_o, timeout_o, locked_o registered one-hot verdict; test_id_o failing test;
//        cycle_cnt_o, ifetch_cnt_o saturating RUN-cycle and fetch counters.
// Optional macro RISCV_SIM_MONITOR_CONSOLE_EN adds CONSOLE_ADDR, console_valid_o and console_data_o.
module riscv_sim_monitor
   import riscv_sim_monitor_pkg::*;
#(
   parameter int                ADDR_W         = 32,
   parameter int                DATA_W         = 32,
   parameter int                CNT_W          = 32,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_1000,
   parameter int                TIMEOUT_CYCLES = 100000,
   parameter int                LOCK_CYCLES    = 16
`ifdef RISCV_SIM_MONITOR_CONSOLE_EN
   ,
   parameter logic [ADDR_W-1:0] CONSOLE_ADDR   = 32'h0000_1004
`endif
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              lock_i,
   input  logic              ird_i,
   input  logic              dwr_i,
   input  logic [ADDR_W-1:0] daddr_i,
   input  logic [DATA_W-1:0] dwdata_i,
   input  logic [1:0]        dsize_i,
   output logic              done_o,
   output logic              pass_o,
   output logic              fail_o,
   output logic              timeout_o,
   output logic              locked_o,
   output logic [DATA_W-2:0] test_id_o,
   output logic [CNT_W-1:0]  cycle_cnt_o,
   output logic [CNT_W-1:0]  ifetch_cnt_o
`ifdef RISCV_SIM_MONITOR_CONSOLE_EN
   ,
   output logic              console_valid_o,
   output logic [7:0]        console_data_o
`endif
);
   localparam int LW = $clog2(LOCK_CYCLES + 1);

   state_t            state, nxt;
   logic              run, hit, lock_exp, to_exp;
   logic [LW-1:0]     lock_run;
   logic [DATA_W-2:0] id_nxt;

   riscv_sim_monitor_cnt #(.W(CNT_W)) u_cycle (
      .clk_i(clk_i), .reset_i(reset_i), .en(run), .clr(1'b0), .cnt(cycle_cnt_o));
   riscv_sim_monitor_cnt #(.W(CNT_W)) u_fetch (
      .clk_i(clk_i), .reset_i(reset_i), .en(run && ird_i), .clr(1'b0), .cnt(ifetch_cnt_o));
   riscv_sim_monitor_cnt #(.W(LW)) u_lock (
      .clk_i(clk_i), .reset_i(reset_i), .en(run && lock_i), .clr(run && !lock_i), .cnt(lock_run));

   // A zero mailbox value is not a verdict, so it is folded into hit.
   // The lock and watchdog tests fire on the cycle that completes the limit,
   // so the verdict is visible right after that edge.
   always_comb begin
      run      = state == RUN;
      hit      = run && dwr_i && daddr_i == TOHOST_ADDR && dsize_i == SIZE_WORD && |dwdata_i;
      lock_exp = run && lock_i && lock_run == LW'(LOCK_CYCLES - 1);
      to_exp   = TIMEOUT_CYCLES != 0 && run && cycle_cnt_o == CNT_W'(TIMEOUT_CYCLES - 1);
      nxt      = state == IDLE ? RUN :
                 !run          ? state :
                 hit           ? ((dwdata_i[0] && dwdata_i[DATA_W-1:1] == '0) ? PASS : FAIL) :
                 lock_exp      ? LOCKED :
                 to_exp        ? TIMEOUT : RUN;
      id_nxt   = !hit       ? test_id_o :
                 dwdata_i[0] ? dwdata_i[DATA_W-1:1] : TEST_ID_ALL_ONES[DATA_W-2:0];
   end

   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) begin
         state     <= IDLE;
         done_o    <= 1'b0;
         pass_o    <= 1'b0;
         fail_o    <= 1'b0;
         timeout_o <= 1'b0;
         locked_o  <= 1'b0;
         test_id_o <= '0;
      end else begin
         state     <= nxt;
         done_o    <= nxt inside {PASS, FAIL, TIMEOUT, LOCKED};
         pass_o    <= nxt == PASS;
         fail_o    <= nxt == FAIL;
         timeout_o <= nxt == TIMEOUT;
         locked_o  <= nxt == LOCKED;
         test_id_o <= id_nxt;
      end

`ifdef RISCV_SIM_MONITOR_CONSOLE_EN
   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) begin
         console_valid_o <= 1'b0;
         console_data_o  <= '0;
      end else begin
         console_valid_o <= run && dwr_i && daddr_i == CONSOLE_ADDR;
         console_data_o  <= (run && dwr_i && daddr_i == CONSOLE_ADDR) ? dwdata_i[7:0] : console_data_o;
      end
`endif
endmodule

// File: tb/tb_riscv_sim_monitor.sv
// tb_riscv_sim_monitor: directed stimulus with a verdict scoreboard for riscv_sim_monitor
module tb_riscv_sim_monitor;
   logic        clk = 1'b0;
   logic        reset_i, lock_i, ird_i, dwr_i;
   logic [31:0] daddr_i, dwdata_i;
   logic [1:0]  dsize_i;
   logic        done_o, pass_o, fail_o, timeout_o, locked_o;
   logic [30:0] test_id_o;
   logic [31:0] cycle_cnt_o, ifetch_cnt_o;
`ifdef RISCV_SIM_MONITOR_CONSOLE_EN
   logic        console_valid_o;
   logic [7:0]  console_data_o;
`endif

   typedef struct {
      logic [3:0]  verdict;
      logic [30:0] id;
      logic [31:0] cyc;
      logic [31:0] ifc;
   } exp_t;
   exp_t q[$];
   int   npass = 0;
   int   ntot  = 0;
   logic done_q = 1'b0;

   riscv_sim_monitor #(.TIMEOUT_CYCLES(200), .LOCK_CYCLES(16)) dut (
      .clk_i(clk), .reset_i(reset_i), .lock_i(lock_i), .ird_i(ird_i), .dwr_i(dwr_i),
      .daddr_i(daddr_i), .dwdata_i(dwdata_i), .dsize_i(dsize_i), .done_o(done_o),
      .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o), .locked_o(locked_o),
      .test_id_o(test_id_o), .cycle_cnt_o(cycle_cnt_o), .ifetch_cnt_o(ifetch_cnt_o)
`ifdef RISCV_SIM_MONITOR_CONSOLE_EN
      , .console_valid_o(console_valid_o), .console_data_o(console_data_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // verdict bits ordered {pass, fail, timeout, locked}
   task automatic expect_verdict(input logic [3:0] v, input logic [30:0] id,
                                 input logic [31:0] cyc, input logic [31:0] ifc);
      exp_t e;
      e.verdict = v;
      e.id      = id;
      e.cyc     = cyc;
      e.ifc     = ifc;
      q.push_back(e);
   endtask

   // Scoreboard monitor: compares on every rising done_o
   always @(negedge clk) begin
      if (done_o && !done_q) begin
         if (q.size() == 0) check("unexpected_done", 1, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            check("verdict", {pass_o, fail_o, timeout_o, locked_o}, e.verdict);
            check("done_is_or", done_o, |e.verdict);
            check("test_id", test_id_o, e.id);
            check("cycle_cnt", cycle_cnt_o, e.cyc);
            check("ifetch_cnt", ifetch_cnt_o, e.ifc);
         end
      end
      done_q <= done_o;
   end

   // One RUN cycle of bus activity; returns at the next negedge
   task automatic cyc(input logic ird, input logic lk, input logic wr,
                      input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      ird_i = ird; lock_i = lk; dwr_i = wr; daddr_i = a; dwdata_i = d; dsize_i = sz;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0, 2'b10);
   endtask

   // Reset, release, and return at the start of RUN cycle 0
   task automatic start();
      reset_i = 1'b0;
      ird_i = 0; lock_i = 0; dwr_i = 0; daddr_i = 0; dwdata_i = 0; dsize_i = 0;
      @(negedge clk);
      reset_i = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      reset_i = 1'b0;
      ird_i = 0; lock_i = 0; dwr_i = 0; daddr_i = 0; dwdata_i = 0; dsize_i = 0;
      @(negedge clk);
      check("reset_flags", {done_o, pass_o, fail_o, timeout_o, locked_o}, 0);
      check("reset_id", test_id_o, 0);
      check("reset_counts", {cycle_cnt_o, ifetch_cnt_o}, 0);
      @(negedge clk);
      reset_i = 1'b1;
      @(negedge clk);

      // pass at RUN cycle 50, fetches on even cycles 0..50
      for (int k = 0; k < 50; k++) cyc(k % 2 == 0, 0, 0, 0, 0, 2'b10);
      expect_verdict(4'b1000, 0, 51, 26);
      cyc(1, 0, 1, 32'h1000, 32'h1, 2'b10);
      cyc(1, 0, 1, 32'h1000, 32'h7, 2'b10);
      cyc(1, 1, 0, 0, 0, 2'b10);
      check("pass_sticky", {pass_o, fail_o}, 2'b10);
      check("pass_frozen", {cycle_cnt_o, ifetch_cnt_o}, {32'd51, 32'd26});

      // odd value with test number, then sticky against a later pass write
      start();
      expect_verdict(4'b0100, 3, 1, 0);
      cyc(0, 0, 1, 32'h1000, 32'h7, 2'b10);
      cyc(0, 0, 1, 32'h1000, 32'h1, 2'b10);
      idle(1);
      check("fail_sticky", {pass_o, fail_o, test_id_o}, {2'b01, 31'd3});

      // even nonzero value reports all-ones test id
      start();
      idle(5);
      expect_verdict(4'b0100, 31'h7FFF_FFFF, 6, 0);
      cyc(0, 0, 1, 32'h1000, 32'h8, 2'b10);
      idle(1);

      // ignored writes, then watchdog after RUN cycle 199
      start();
      idle(10);
      cyc(0, 0, 1, 32'h1000, 32'h1, 2'b00);
      cyc(0, 0, 1, 32'h1000, 32'h0, 2'b10);
      cyc(0, 0, 1, 32'h1008, 32'h1, 2'b10);
      idle(10);
      check("no_verdict", done_o, 0);
      expect_verdict(4'b0010, 0, 200, 0);
      for (int i = 0; i < 400 && !done_o; i++) idle(1);
      idle(1);

      // 15 lock, 1 gap, 16 lock
      start();
      for (int k = 0; k < 15; k++) cyc(0, 1, 0, 0, 0, 2'b10);
      cyc(0, 0, 0, 0, 0, 2'b10);
      for (int k = 0; k < 15; k++) cyc(0, 1, 0, 0, 0, 2'b10);
      check("lock_not_yet", done_o, 0);
      expect_verdict(4'b0001, 0, 32, 0);
      cyc(0, 1, 0, 0, 0, 2'b10);
      idle(2);

      // mailbox pass coincides with lock expiry
      start();
      for (int k = 0; k < 15; k++) cyc(0, 1, 0, 0, 0, 2'b10);
      expect_verdict(4'b1000, 0, 16, 0);
      cyc(0, 1, 1, 32'h1000, 32'h1, 2'b10);
      idle(2);

      // asynchronous reset mid-run, then fetch count restarts
      start();
      for (int k = 0; k < 10; k++) cyc(k % 2 == 1, 0, 0, 0, 0, 2'b10);
      #2 reset_i = 1'b0;
      #1;
      check("async_flags", {done_o, pass_o, fail_o, timeout_o, locked_o}, 0);
      check("async_counts", {cycle_cnt_o, ifetch_cnt_o}, 0);
      @(negedge clk);
      reset_i = 1'b1;
      @(negedge clk);
      cyc(1, 0, 0, 0, 0, 2'b10);
      cyc(1, 0, 0, 0, 0, 2'b10);
      cyc(1, 0, 0, 0, 0, 2'b10);
      idle(2);
      cyc(1, 0, 0, 0, 0, 2'b10);
      idle(3);
      expect_verdict(4'b1000, 0, 10, 4);
      cyc(0, 0, 1, 32'h1000, 32'h1, 2'b10);
      idle(2);

`ifdef RISCV_SIM_MONITOR_CONSOLE_EN
      start();
      idle(3);
      cyc(0, 0, 1, 32'h1004, 32'h0000_0A41, 2'b00);
      check("console_pulse", {console_valid_o, console_data_o}, {1'b1, 8'h41});
      idle(1);
      check("console_end", console_valid_o, 0);
      check("console_no_verdict", done_o, 0);
`endif

      idle(2);
      check("scoreboard_empty", q.size(), 0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
